// File: rtl/line_fill_assembler.sv
// ---------------------------------------------------------------------------
// line_fill_assembler
//
// Collects the 32-bit beats of a wrapping, critical-word-first AHB refill burst
// into one cache line for the I-cache data/tag arrays. The miss address is split
// into tag / index / start offset. The first beat is forwarded early as the
// critical word. The finished line is then presented for one cycle with its tag,
// index and an error flag. The line stays stable until the next fill starts.
//
// Ports
//   HCLK, HRESETn   clock (rising edge), asynchronous active-low reset
//   fill_req        start a refill (only looked at while idle)
//   fill_addr       miss byte address, bits [1:0] ignored
//   fill_abort      abandon the fill in progress (no line is presented)
//   beat_valid      a refill beat is on beat_data this cycle
//   beat_data       refill beat
//   beat_err        the beat carried an AHB ERROR response
//   fill_busy       a fill is in progress or its line is being presented
//   crit_valid      one-cycle pulse, crit_data holds the critical word
//   crit_data       critical (first) word of the burst
//   line_valid      one-cycle pulse, line complete
//   line_data       assembled line, word w at [32w+31:32w]
//   line_tag        tag part of the miss address
//   line_index      index part of the miss address
//   line_err        some beat of this line reported an error
// ---------------------------------------------------------------------------
module line_fill_assembler #(
  parameter int CACHE_LINE = 128,
  parameter int CACHE_SIZE = 8192,
  localparam int WORDS = CACHE_LINE / 32,
  localparam int OFF_W = $clog2(WORDS),
  localparam int IDX_W = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
  localparam int TAG_W = 30 - OFF_W - IDX_W
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  fill_req,
  input  logic [31:0]           fill_addr,
  input  logic                  fill_abort,
  input  logic                  beat_valid,
  input  logic [31:0]           beat_data,
  input  logic                  beat_err,
  output logic                  fill_busy,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  line_valid,
  output logic [CACHE_LINE-1:0] line_data,
  output logic [TAG_W-1:0]      line_tag,
  output logic [IDX_W-1:0]      line_index,
  output logic                  line_err
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                 state;
  logic [OFF_W-1:0]       start_off;
  logic [OFF_W-1:0]       beat_cnt;
  logic [OFF_W-1:0]       word_sel;
  logic [WORDS-1:0][31:0] line_words;

  // The burst wraps inside the line, so the destination word is simply the
  // start offset plus the beat count, truncated to OFF_W bits.
  assign word_sel  = start_off + beat_cnt;
  assign line_data = line_words;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      fill_busy  <= 1'b0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      line_valid <= 1'b0;
      line_words <= '0;
      line_tag   <= '0;
      line_index <= '0;
      line_err   <= 1'b0;
      start_off  <= '0;
      beat_cnt   <= '0;
    end else begin
      crit_valid <= 1'b0;
      line_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // A simultaneous abort is meaningless here, so the request wins.
          if (fill_req) begin
            state      <= FILL;
            fill_busy  <= 1'b1;
            line_tag   <= fill_addr[31 -: TAG_W];
            line_index <= fill_addr[2 + OFF_W +: IDX_W];
            start_off  <= fill_addr[2 +: OFF_W];
            beat_cnt   <= '0;
            line_err   <= 1'b0;
            line_words <= '0;
          end
        end
        FILL: begin
          if (beat_valid) begin
            line_words[word_sel] <= beat_data;
            // The first beat of the burst is the critical word. Its pulse is
            // issued even if the fill is aborted in the same cycle.
            if (beat_cnt == '0) begin
              crit_valid <= 1'b1;
              crit_data  <= beat_data;
            end
            // Errors are only flagged. The burst still runs to full length.
            if (beat_err) line_err <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (fill_abort) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
          end else if (beat_valid && (&beat_cnt)) begin
            state      <= DONE;
            line_valid <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
